// File: rtl/main_fsm_pkg.sv
// rtl/main_fsm_pkg.sv - state, opcode and select encodings for the multicycle controller
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/main_fsm_imm_src_decoder.sv
// rtl/main_fsm_imm_src_decoder.sv - immediate format select from the opcode
module imm_src_decoder
  import main_fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - Moore sequencer for the multicycle RISC-V datapath
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic               zero,
  output logic [1:0]         alu_op,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic               adr_src,
  output logic [1:0]         imm_src,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_write,
  output logic               pc_write,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state_q, state_d;
  logic   ir_w, reg_w, mem_w, pc_update, branch, illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    alu_op     = ALU_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_WD;
    result_src = RES_ALUOUT;
    adr_src    = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_w       = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes OldPC + imm as the branch/jump target
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: reg_w = 1'b1;
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are masked during reset so FETCH's ir/pc writes never fire while held
  assign ir_write   = ir_w & reset_n;
  assign reg_write  = reg_w & reset_n;
  assign mem_write  = mem_w & reset_n;
  assign pc_write   = (pc_update | (branch & zero)) & reset_n;
  assign illegal_op = illegal & reset_n;
  assign state_dbg  = STATE_W'(state_q);

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (imm_src)
  );

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - scoreboard bench for main_fsm state sequencing and outputs
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       zero;
  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src, imm_src;
  logic       adr_src, ir_write, reg_write, mem_write, pc_write, illegal_op;
  logic [3:0] state_dbg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [19:0] rec;
    string       tag;
  } exp_t;
  exp_t sb[$];

  main_fsm #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .zero       (zero),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .adr_src    (adr_src),
    .imm_src    (imm_src),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .pc_write   (pc_write),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Record layout: state, alu_op, src_a, src_b, result_src, adr_src, imm_src, ir, rw, mw, pcw, illegal
  function automatic logic [19:0] pack(input logic [3:0] st, input logic [1:0] aop,
      input logic [1:0] sa, input logic [1:0] sb_, input logic [1:0] rs, input logic adr,
      input logic [1:0] imm, input logic irw, input logic rw, input logic mw,
      input logic pcw, input logic ill);
    return {st, aop, sa, sb_, rs, adr, imm, irw, rw, mw, pcw, ill};
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [19:0] exp_rec(input logic [3:0] st, input logic [6:0] o,
      input logic z, input logic ill);
    logic [1:0] im;
    im = exp_imm(o);
    case (st)
      4'd0:    return pack(st, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, im, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      4'd1:    return pack(st, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, im, 1'b0, 1'b0, 1'b0, 1'b0, ill);
      4'd2:    return pack(st, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      4'd3:    return pack(st, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      4'd4:    return pack(st, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, im, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      4'd5:    return pack(st, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, im, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      4'd6:    return pack(st, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      4'd7:    return pack(st, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, im, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      4'd8:    return pack(st, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      4'd9:    return pack(st, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, im, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      4'd10:   return pack(st, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, im, 1'b0, 1'b0, 1'b0, z, 1'b0);
      default: return 20'hxxxxx;
    endcase
  endfunction

  function automatic logic [19:0] observed();
    return pack(state_dbg, alu_op, alu_src_a, alu_src_b, result_src, adr_src, imm_src,
                ir_write, reg_write, mem_write, pc_write, illegal_op);
  endfunction

  task automatic push(input logic [3:0] st, input string tag, input logic ill = 1'b0);
    exp_t e;
    e.rec = exp_rec(st, op, zero, ill);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [19:0] got;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_underflow got=empty exp=entry");
      return;
    end
    e = sb.pop_front();
    got = observed();
    checks++;
    assert (got === e.rec) else begin
      failures++;
      $error("FAIL %s got=%05h exp=%05h", e.tag, got, e.rec);
    end
  endtask

  // Starts at a negedge in FETCH; ends at the negedge of the following FETCH
  task automatic run(input logic [6:0] o, input logic z, input logic [3:0] path[], input string tag);
    op = o;
    zero = z;
    foreach (path[i]) push(path[i], $sformatf("%s_s%0d_c%0d", tag, path[i], i), (tag == "ill") && i == 1);
    for (int i = 0; i < path.size(); i++) begin
      #1 pop_check();
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] p_lw[], p_sw[], p_r[], p_i[], p_jal[], p_beq[], p_ill[], p_pre[];
    exp_t e;
    p_lw  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    p_sw  = '{4'd0, 4'd1, 4'd2, 4'd5};
    p_r   = '{4'd0, 4'd1, 4'd6, 4'd7};
    p_i   = '{4'd0, 4'd1, 4'd8, 4'd7};
    p_jal = '{4'd0, 4'd1, 4'd9, 4'd7};
    p_beq = '{4'd0, 4'd1, 4'd10};
    p_ill = '{4'd0, 4'd1};
    p_pre = '{4'd0, 4'd1, 4'd2, 4'd5};

    reset_n = 1'b0;
    op = 7'b0000011;
    zero = 1'b0;
    #3;
    e.rec = pack(4'd0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.tag = "reset_hold";
    sb.push_back(e);
    pop_check();
    @(negedge clk);
    reset_n = 1'b1;

    run(7'b0000011, 1'b0, p_lw,  "lw");
    run(7'b0100011, 1'b0, p_sw,  "sw");
    run(7'b0110011, 1'b0, p_r,   "rtype");
    run(7'b0010011, 1'b0, p_i,   "addi");
    run(7'b1100011, 1'b1, p_beq, "beq_taken");
    run(7'b1100011, 1'b0, p_beq, "beq_not");
    run(7'b1111111, 1'b0, p_ill, "ill");
    run(7'b1101111, 1'b0, p_jal, "jal");

    // Abort in the middle of MEMWRITE: state and mem_write drop without a clock edge
    op = 7'b0100011;
    foreach (p_pre[i]) push(p_pre[i], $sformatf("pre_reset_c%0d", i));
    for (int i = 0; i < 4; i++) begin
      #1 pop_check();
      if (i < 3) @(negedge clk);
    end
    #1 reset_n = 1'b0;
    #1;
    e.rec = pack(4'd0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.tag = "reset_midwrite";
    sb.push_back(e);
    pop_check();
    @(negedge clk);
    reset_n = 1'b1;
    #1 push(4'd0, "post_reset_fetch");
    pop_check();
    @(negedge clk);
    #1 push(4'd1, "post_reset_decode");
    pop_check();

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
